// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the shared-ALU arbiter/sequencer.
package alu_share_arb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSTR_HI_W = 20;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above ptr_i, with wrap-around.
module alu_share_arb_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            j = int'(ptr_i) + k;
            if (j >= int'(NUM_REQ)) begin
                j = j - int'(NUM_REQ);
            end
            if (en_i && !found && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between NUM_REQ requesters: arbitrate, register operands,
// capture the result one cycle later and return it over a valid/ready response channel.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*XLEN-1:0]       req_x1,
    input  logic [NUM_REQ*XLEN-1:0]       req_x2,
    input  logic [NUM_REQ*INSTR_HI_W-1:0] req_instr,
    input  logic [NUM_REQ-1:0]            req_opcode_4,
    input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
    output logic [XLEN-1:0]               alu_x1,
    output logic [XLEN-1:0]               alu_x2,
    output logic [INSTR_HI_W-1:0]         alu_instr,
    output logic                          alu_opcode_4,
    output logic                          alu_cin,
    input  logic [XLEN-1:0]               alu_y,
    input  logic                          alu_cout,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [XLEN-1:0]               rsp_y,
    output logic                          rsp_cout,
    output logic [ID_W-1:0]               rsp_id,
    output logic [TAG_W-1:0]              rsp_tag,
    output logic [XLEN-1:0]               op_count
);

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [XLEN-1:0]         x1_q, x1_d, x2_q, x2_d;
    logic [INSTR_HI_W-1:0]   instr_q, instr_d;
    logic                    op4_q, op4_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]         y_q, y_d;
    logic                    cout_q, cout_d;
    logic [XLEN-1:0]         cnt_q, cnt_d;

    logic                    grant_ok;
    logic [NUM_REQ-1:0]      gnt;
    logic [ID_W-1:0]         gnt_idx;
    logic                    fire;

    // Gated by rst_n so no requester sees ready while the block is held in reset.
    assign grant_ok = rst_n &&
                      ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));

    alu_share_arb_rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_rr_arbiter (
        .req_i(req_valid),
        .ptr_i(ptr_q),
        .en_i (grant_ok),
        .gnt_o(gnt),
        .idx_o(gnt_idx)
    );

    assign req_ready = gnt;
    assign fire      = |gnt;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        instr_d     = instr_q;
        op4_d       = op4_q;
        tag_d       = tag_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        y_d         = y_q;
        cout_d      = cout_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (fire) state_d = StExec;
            end
            StExec: begin
                y_d         = alu_y;
                cout_d      = alu_cout;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    cnt_d       = cnt_q + 32'd1;
                    rsp_valid_d = 1'b0;
                    state_d     = fire ? StExec : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (fire) begin
            x1_d    = req_x1[XLEN*int'(gnt_idx) +: XLEN];
            x2_d    = req_x2[XLEN*int'(gnt_idx) +: XLEN];
            instr_d = req_instr[INSTR_HI_W*int'(gnt_idx) +: INSTR_HI_W];
            op4_d   = req_opcode_4[gnt_idx];
            tag_d   = req_tag[TAG_W*int'(gnt_idx) +: TAG_W];
            id_d    = gnt_idx;
            ptr_d   = (int'(gnt_idx) == int'(NUM_REQ) - 1) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            instr_q     <= '0;
            op4_q       <= 1'b0;
            tag_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            y_q         <= '0;
            cout_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            instr_q     <= instr_d;
            op4_q       <= op4_d;
            tag_q       <= tag_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            y_q         <= y_d;
            cout_q      <= cout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign alu_x1       = x1_q;
    assign alu_x2       = x2_q;
    assign alu_instr    = instr_q;
    assign alu_opcode_4 = op4_q;
    assign alu_cin      = 1'b0;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_y        = y_q;
    assign rsp_cout     = cout_q;
    assign rsp_id       = id_q;
    assign rsp_tag      = tag_q;
    assign op_count     = cnt_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: grants push expected responses, a monitor pops and compares.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_x1, req_x2;
    logic [39:0] req_instr;
    logic [1:0]  req_opcode_4;
    logic [7:0]  req_tag;
    logic [31:0] alu_x1, alu_x2, alu_y;
    logic [19:0] alu_instr;
    logic        alu_opcode_4, alu_cin, alu_cout;
    logic        rsp_valid, rsp_ready, rsp_cout;
    logic [31:0] rsp_y, op_count;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_tag;

    alu_share_arb #(.NUM_REQ(2), .TAG_W(4), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .req_instr(req_instr),
        .req_opcode_4(req_opcode_4), .req_tag(req_tag),
        .alu_x1(alu_x1), .alu_x2(alu_x2), .alu_instr(alu_instr),
        .alu_opcode_4(alu_opcode_4), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_cout(rsp_cout), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the external shared ALU.
    always_comb begin
        logic [31:0] op2;
        logic [32:0] sum;
        op2      = alu_opcode_4 ? alu_x2 : {{20{alu_instr[19]}}, alu_instr[19:8]};
        sum      = {1'b0, alu_x1} + {1'b0, op2} + {32'd0, alu_cin};
        alu_y    = 32'd0;
        alu_cout = 1'b0;
        case (alu_instr[2:0])
            3'b000: begin
                if (alu_opcode_4 && alu_instr[18]) begin
                    alu_y = alu_x1 - op2;
                end else begin
                    alu_y    = sum[31:0];
                    alu_cout = sum[32];
                end
            end
            3'b100:  alu_y = alu_x1 ^ op2;
            3'b110:  alu_y = alu_x1 | op2;
            3'b111:  alu_y = alu_x1 & op2;
            default: alu_y = 32'd0;
        endcase
    end

    typedef struct {
        logic [31:0] y;
        logic        c;
        int          id;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          gnt_order[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_gnt    = 0;
    int          cyc      = 0;
    bit          seen     = 1'b0;
    logic [31:0] e_y[2];
    logic        e_c[2];
    logic [3:0]  e_tag[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Grant watcher: every accepted request pushes its hand-computed response.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{y: e_y[i], c: e_c[i], id: i, tag: e_tag[i], cyc: cyc});
                    gnt_order.push_back(i);
                    n_gnt++;
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_y 0x%08h with no expected entry", rsp_y);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - sb[0].cyc), 32'd2);
                    seen = 1'b1;
                end
                if (rsp_ready) begin
                    chk("rsp_y", rsp_y, sb[0].y);
                    chk("rsp_cout", 32'(rsp_cout), 32'(sb[0].c));
                    chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                    chk("rsp_tag", 32'(rsp_tag), 32'(sb[0].tag));
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] x1, input logic [31:0] x2,
                           input logic [19:0] instr, input logic op4, input logic [3:0] tag,
                           input logic [31:0] ey, input logic ec);
        req_x1[i*32 +: 32]    = x1;
        req_x2[i*32 +: 32]    = x2;
        req_instr[i*20 +: 20] = instr;
        req_opcode_4[i]       = op4;
        req_tag[i*4 +: 4]     = tag;
        e_y[i]   = ey;
        e_c[i]   = ec;
        e_tag[i] = tag;
    endtask

    task automatic wait_gnt(input int target, input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(posedge clk);
            #1;
            if (n_gnt >= target) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: grants %0d expected %0d within budget", name, n_gnt, target);
        end
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !rsp_valid) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: %0d responses outstanding, expected 0", name, sb.size());
        end
    endtask

    task automatic req0_xor(input logic [3:0] tag);
        set_req(0, 32'hF0F0_0000, 32'h0FF0_0000, 20'h00004, 1'b1, tag, 32'hFF00_0000, 1'b0);
    endtask

    task automatic req1_ori(input logic [3:0] tag);
        set_req(1, 32'h0000_0100, 32'h0, 20'h0FF06, 1'b0, tag, 32'h0000_01FF, 1'b0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        req_valid = '0; req_x1 = '0; req_x2 = '0; req_instr = '0;
        req_opcode_4 = '0; req_tag = '0; rsp_ready = 1'b0;
        req0_xor(4'h1);
        req1_ori(4'hA);
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_op_count", op_count, 32'd0);
        chk("reset_alu_x1", alu_x1, 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b1;

        // XOR reg-reg on req0, ADD with carry on req0, then ORI on req1.
        req0_xor(4'h1);
        req_valid = 2'b01;
        wait_gnt(1, "gnt_xor");
        req_valid = 2'b00;
        drain("drain_xor");
        set_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 20'h00000, 1'b1, 4'h3, 32'h0, 1'b1);
        req_valid = 2'b01;
        wait_gnt(2, "gnt_add");
        req_valid = 2'b00;
        drain("drain_add");
        req1_ori(4'hA);
        req_valid = 2'b10;
        wait_gnt(3, "gnt_ori");
        req_valid = 2'b00;
        drain("drain_ori");
        chk("op_count_3", op_count, 32'd3);

        // Fairness: both held for 8 grants starting from pointer 0.
        req0_xor(4'h5);
        req1_ori(4'hA);
        base = n_gnt;
        req_valid = 2'b11;
        wait_gnt(base + 8, "gnt_fair");
        req_valid = 2'b00;
        drain("drain_fair");
        for (int k = 0; k < 8; k++) begin
            chk("fair_order", 32'(gnt_order[base + k]), 32'(k % 2));
        end
        chk("op_count_11", op_count, 32'd11);

        // Backpressure: hold the response 5 cycles, then grant the pending req1 in the same cycle.
        rsp_ready = 1'b0;
        req0_xor(4'h7);
        req_valid = 2'b01;
        wait_gnt(n_gnt + 1, "gnt_bp0");
        req1_ori(4'hB);
        req_valid = 2'b10;
        for (int t = 0; t < 10 && !rsp_valid; t++) begin
            @(posedge clk); #1;
        end
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_y", rsp_y, 32'hFF00_0000);
            chk("bp_rsp_id", 32'(rsp_id), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        base = n_gnt;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_grant", 32'(req_ready), 32'd2);
        wait_gnt(base + 1, "gnt_bp1");
        req_valid = 2'b00;
        drain("drain_bp");
        chk("op_count_13", op_count, 32'd13);

        // Counter wrap.
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.cnt_q;
        chk("op_count_preload", op_count, 32'hFFFF_FFFF);
        set_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 20'h00000, 1'b1, 4'h2, 32'h0, 1'b1);
        req_valid = 2'b01;
        wait_gnt(n_gnt + 1, "gnt_wrap");
        req_valid = 2'b00;
        drain("drain_wrap");
        chk("op_count_wrap", op_count, 32'd0);

        // Reset in EXEC: in-flight op dropped, pointer back to 0.
        req0_xor(4'h9);
        req1_ori(4'hC);
        req_valid = 2'b01;
        wait_gnt(n_gnt + 1, "gnt_pre_rst");
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_op_count", op_count, 32'd0);
        chk("mid_rst_alu_x1", alu_x1, 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        base = n_gnt;
        rst_n = 1'b1;
        wait_gnt(base + 1, "gnt_post_rst");
        req_valid = 2'b00;
        chk("post_rst_first_gnt", 32'(gnt_order[base]), 32'd0);
        drain("drain_post_rst");
        chk("op_count_post_rst", op_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
